// File: rtl/bcd_pkg.sv
// Shared types, constants and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic {
        IDLE,
        CONVERT
    } state_t;

    localparam logic [3:0] BCD_BLANK = 4'hF;

    function automatic logic [3:0] add3_if_ge5(logic [3:0] d);
        return (d >= 4'd5) ? 4'(d + 4'd3) : d;
    endfunction

    // True when DIGITS decimal digits can hold every BIN_W-bit unsigned value.
    function automatic bit bcd_fits(int unsigned bin_w, int unsigned digits);
        longint unsigned p10;
        longint unsigned max_bin;
        p10 = 64'd1;
        for (int unsigned i = 0; i < digits; i++) begin
            p10 = p10 * 64'd10;
        end
        max_bin = (64'd1 << bin_w) - 64'd1;
        return p10 > max_bin;
    endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add-3 correction on every digit, then shift in one bit.
module bcd_dabble_step
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 3
) (
    input  logic [4*DIGITS-1:0] bcd_in,
    input  logic                bit_in,
    output logic [4*DIGITS-1:0] bcd_c
);

    logic [4*DIGITS-1:0] corrected;

    always_comb begin
        corrected = bcd_in;
        for (int i = 0; i < int'(DIGITS); i++) begin
            corrected[4*i +: 4] = add3_if_ge5(bcd_in[4*i +: 4]);
        end
        bcd_c = {corrected[4*DIGITS-2:0], bit_in};
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter with registered BCD and leading-zero-blanked display outputs.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int unsigned BIN_W    = 8,
    parameter int unsigned DIGITS   = 3,
    parameter int unsigned BLANK_LZ = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [BIN_W-1:0]    bin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd,
    output logic [4*DIGITS-1:0] disp
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    if (BIN_W < 1 || !bcd_fits(BIN_W, DIGITS)) begin : g_bad_cfg
        $error("bin_to_bcd_seq: DIGITS too small for BIN_W");
    end

    // Replace zero digits above the most significant nonzero digit; digit 0 always shows.
    function automatic logic [BCD_W-1:0] blank_lz(logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        logic             lead;
        r    = v;
        lead = 1'b1;
        if (BLANK_LZ != 0) begin
            for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
                if (lead && v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = BCD_BLANK;
                end else begin
                    lead = 1'b0;
                end
            end
        end
        return r;
    endfunction

    localparam logic [BCD_W-1:0] DISP_RST = blank_lz('0);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIN_W-1:0]   shift_q, shift_d;
    logic [BCD_W-1:0]   work_q, work_d;
    logic [BCD_W-1:0]   step_c;
    logic               busy_d, done_d;
    logic [BCD_W-1:0]   bcd_d, disp_d;

    bcd_dabble_step #(.DIGITS(DIGITS)) u_step (
        .bcd_in (work_q),
        .bit_in (shift_q[BIN_W-1]),
        .bcd_c  (step_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            work_q  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd     <= '0;
            disp    <= DISP_RST;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            work_q  <= work_d;
            busy    <= busy_d;
            done    <= done_d;
            bcd     <= bcd_d;
            disp    <= disp_d;
        end
    end

    // Next state and next register values; results are published only on the last iteration.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        work_d  = work_q;
        busy_d  = busy;
        done_d  = 1'b0;
        bcd_d   = bcd;
        disp_d  = disp;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d = bin;
                    work_d  = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                work_d  = step_c;
                shift_d = BIN_W'(shift_q << 1);
                cnt_d   = CNT_W'(cnt_q + 1'b1);
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    bcd_d   = step_c;
                    disp_d  = blank_lz(step_c);
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
